// File: rtl/pipeline_id_ex_skid.sv
// ID/EX elastic pipeline buffer: 2-entry skid (main + skid register) with flush and bubble insertion.
// Latency: 1 cycle from acceptance in EMPTY to m_*; sustains 1 instr/cycle while m_ready stays high.
// Backpressure: s_ready registered-state based (not FULL, no flush); never combinational from m_ready.
`timescale 1ns/1ps
module pipeline_id_ex_skid #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CTRL_W-1:0] s_ctrl,
    input  logic [XLEN-1:0]   s_pc,
    input  logic [REG_W-1:0]  s_rs1,
    input  logic [REG_W-1:0]  s_rs2,
    input  logic [REG_W-1:0]  s_rd,
    input  logic [XLEN-1:0]   s_imm,
    input  logic [XLEN-1:0]   s_pcplus4,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CTRL_W-1:0] m_ctrl,
    output logic [XLEN-1:0]   m_pc,
    output logic [REG_W-1:0]  m_rs1,
    output logic [REG_W-1:0]  m_rs2,
    output logic [REG_W-1:0]  m_rd,
    output logic [XLEN-1:0]   m_imm,
    output logic [XLEN-1:0]   m_pcplus4,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    // Datapath fields travel as one packed word; ctrl is kept apart so it can be zeroed alone.
    localparam int DAT_W = 3*XLEN + 3*REG_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DAT_W-1:0]    main_dat_q, main_dat_d;
    logic [DAT_W-1:0]    skid_dat_q, skid_dat_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [DAT_W-1:0]    s_dat;
    logic                acc, pop;

    assign s_dat   = {s_pc, s_rs1, s_rs2, s_rd, s_imm, s_pcplus4};
    assign s_ready = (state_q != ST_FULL) && !i_flush;
    assign m_valid = (state_q != ST_EMPTY);
    assign acc     = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    // Next-state and entry moves; a bubble always carries zero ctrl so execute sees a NOP.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_dat_d  = main_dat_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_dat_d  = skid_dat_q;
        if (i_flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = s_ctrl;
                        main_dat_d  = s_dat;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        main_ctrl_d = s_ctrl;
                        main_dat_d  = s_dat;
                    end else if (acc) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = s_ctrl;
                        skid_dat_d  = s_dat;
                    end else if (pop) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                ST_FULL: begin
                    // s_ready is low here, so only the drain path exists.
                    if (pop) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_dat_d  = skid_dat_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
    end

    // Saturating count of cycles where execute holds off a valid instruction; flush leaves it alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid && !m_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State and storage registers; reset wins over flush and any handshake.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_dat_q  <= '0;
            skid_ctrl_q <= '0;
            skid_dat_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_dat_q  <= main_dat_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_dat_q  <= skid_dat_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign m_ctrl = main_ctrl_q;
    assign {m_pc, m_rs1, m_rs2, m_rd, m_imm, m_pcplus4} = main_dat_q;
    assign o_occupancy = state_q;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_id_ex_skid.sv
`timescale 1ns/1ps
module tb_pipeline_id_ex_skid;

    logic        i_clk = 1'b0;
    logic        i_rstn, i_flush, s_valid, m_ready;
    logic [11:0] s_ctrl;
    logic [31:0] s_pc, s_imm, s_pcplus4;
    logic [4:0]  s_rs1, s_rs2, s_rd;

    logic        s_ready, m_valid;
    logic [11:0] m_ctrl;
    logic [31:0] m_pc, m_imm, m_pcplus4;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [1:0]  o_occupancy;
    logic [15:0] o_stall_cnt;

    logic        d4_s_ready, d4_m_valid;
    logic [11:0] d4_m_ctrl;
    logic [31:0] d4_m_pc, d4_m_imm, d4_m_pcplus4;
    logic [4:0]  d4_m_rs1, d4_m_rs2, d4_m_rd;
    logic [1:0]  d4_occ;
    logic [3:0]  d4_cnt;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    pipeline_id_ex_skid #(.XLEN(32), .CTRL_W(12), .REG_W(5), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_ctrl(s_ctrl), .s_pc(s_pc),
        .s_rs1(s_rs1), .s_rs2(s_rs2), .s_rd(s_rd), .s_imm(s_imm), .s_pcplus4(s_pcplus4),
        .m_valid(m_valid), .m_ready(m_ready), .m_ctrl(m_ctrl), .m_pc(m_pc),
        .m_rs1(m_rs1), .m_rs2(m_rs2), .m_rd(m_rd), .m_imm(m_imm), .m_pcplus4(m_pcplus4),
        .o_occupancy(o_occupancy), .o_stall_cnt(o_stall_cnt)
    );

    pipeline_id_ex_skid #(.XLEN(32), .CTRL_W(12), .REG_W(5), .CNT_W(4)) dut4 (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
        .s_valid(s_valid), .s_ready(d4_s_ready), .s_ctrl(s_ctrl), .s_pc(s_pc),
        .s_rs1(s_rs1), .s_rs2(s_rs2), .s_rd(s_rd), .s_imm(s_imm), .s_pcplus4(s_pcplus4),
        .m_valid(d4_m_valid), .m_ready(m_ready), .m_ctrl(d4_m_ctrl), .m_pc(d4_m_pc),
        .m_rs1(d4_m_rs1), .m_rs2(d4_m_rs2), .m_rd(d4_m_rd), .m_imm(d4_m_imm), .m_pcplus4(d4_m_pcplus4),
        .o_occupancy(d4_occ), .o_stall_cnt(d4_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [127:0] sb_q[$];
    int           mdl_occ   = 0;
    int           mdl_stall = 0;
    int           mdl_st4   = 0;
    bit           chk_en    = 0;

    always @(negedge i_clk) begin
        logic         exp_rdy, acc_m, pop_m;
        logic [127:0] cur, e;
        exp_rdy = (mdl_occ != 2) && !i_flush;
        pop_m   = (mdl_occ != 0) && m_ready;
        acc_m   = s_valid && exp_rdy;
        if (chk_en) begin
            chk("m_valid", m_valid, mdl_occ != 0);
            chk("s_ready", s_ready, exp_rdy);
            chk("occupancy", o_occupancy, mdl_occ);
            chk("stall_cnt", o_stall_cnt, mdl_stall);
            chk("stall_cnt4", d4_cnt, mdl_st4);
            chk("d4_m_valid", d4_m_valid, mdl_occ != 0);
            if (mdl_occ == 0) chk("bubble_ctrl", m_ctrl, 0);
            if (pop_m) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e   = sb_q.pop_front();
                    cur = {5'b0, m_ctrl, m_pc, m_rs1, m_rs2, m_rd, m_imm, m_pcplus4};
                    chk("sb_entry", cur, e);
                end
            end
        end
        if (!i_rstn) begin
            mdl_occ = 0; mdl_stall = 0; mdl_st4 = 0;
            sb_q.delete();
            chk_en = 1;
        end else if (chk_en) begin
            if (mdl_occ != 0 && !m_ready) begin
                if (mdl_stall < 65535) mdl_stall++;
                if (mdl_st4 < 15) mdl_st4++;
            end
            if (i_flush) begin
                mdl_occ = 0;
                sb_q.delete();
            end else begin
                if (acc_m) sb_q.push_back({5'b0, s_ctrl, s_pc, s_rs1, s_rs2, s_rd, s_imm, s_pcplus4});
                mdl_occ = mdl_occ + (acc_m ? 1 : 0) - (pop_m ? 1 : 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [11:0] ctrl);
        s_pc      = pc;
        s_ctrl    = ctrl;
        s_rs1     = pc[6:2];
        s_rs2     = pc[7:3] ^ 5'h13;
        s_rd      = pc[4:0] + 5'd1;
        s_imm     = ~pc;
        s_pcplus4 = pc + 32'd4;
    endtask

    // Offer one instruction and hold it until the buffer takes it.
    task automatic send(input logic [31:0] pc, input logic [11:0] ctrl);
        logic got;
        int   n;
        set_in(pc, ctrl);
        s_valid = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            got = s_ready;
            @(posedge i_clk);
            #1;
            n++;
        end while (!got && n < 50);
        if (!got) chk("send_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        tick(1);
        i_rstn = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        i_rstn = 1'b0; i_flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        set_in(32'h0, 12'h0);
        tick(2);
        i_rstn = 1'b1;

        // reset state
        @(negedge i_clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_fields", {m_ctrl, m_pc, m_rs1, m_rs2, m_rd, m_imm, m_pcplus4}, 0);
        chk("rst_occ", o_occupancy, 0);
        chk("rst_s_ready", s_ready, 1);
        tick(1);

        // streaming at full rate
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'(i * 4), 12'h0A5 ^ 12'(i));
            chk("strm_occ", o_occupancy, 1);
        end
        tick(3);

        // backpressure into FULL, then drain in order
        m_ready = 1'b0;
        send(32'h100, 12'h155);
        send(32'h104, 12'h2AA);
        set_in(32'h108, 12'h3C3);
        s_valid = 1'b1;
        tick(2);
        chk("bp_occ", o_occupancy, 2);
        chk("bp_s_ready", s_ready, 0);
        m_ready = 1'b1;
        send(32'h108, 12'h3C3);
        tick(4);

        // flush while FULL of all-ones ctrl; an s_valid during flush is ignored
        m_ready = 1'b0;
        send(32'h300, 12'hFFF);
        send(32'h304, 12'hFFF);
        chk("fl_occ_full", o_occupancy, 2);
        i_flush = 1'b1;
        set_in(32'h308, 12'hFFF);
        s_valid = 1'b1;
        tick(1);
        i_flush = 1'b0;
        s_valid = 1'b0;
        @(negedge i_clk);
        chk("fl_m_valid", m_valid, 0);
        chk("fl_m_ctrl", m_ctrl, 0);
        chk("fl_occ", o_occupancy, 0);
        chk("fl_s_ready", s_ready, 1);
        tick(2);
        chk("fl_no_accept", m_valid, 0);

        // simultaneous accept and pop in ONE
        send(32'h200, 12'h0F0);
        m_ready = 1'b1;
        send(32'h204, 12'h00F);
        chk("sim_pc", m_pc, 32'h204);
        chk("sim_occ", o_occupancy, 1);
        tick(3);

        // reset in the middle of a stall
        do_reset();
        m_ready = 1'b0;
        send(32'h400, 12'h111);
        send(32'h404, 12'h222);
        n = 0;
        while (mdl_stall < 5 && n < 50) begin
            tick(1);
            n++;
        end
        chk("mid_cnt", o_stall_cnt, 5);
        chk("mid_occ", o_occupancy, 2);
        do_reset();
        @(negedge i_clk);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_fields", {m_ctrl, m_pc, m_rs1, m_rs2, m_rd, m_imm, m_pcplus4}, 0);
        chk("mid_rst_occ", o_occupancy, 0);
        chk("mid_rst_cnt", o_stall_cnt, 0);
        tick(1);

        // stall counter saturation on the 4-bit instance
        m_ready = 1'b0;
        send(32'h500, 12'h800);
        tick(20);
        chk("sat4", d4_cnt, 15);
        chk("sat16", o_stall_cnt, 20);
        m_ready = 1'b1;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
